memory_board_scan: RTL and testbench
====================================

# memory_board_scan

Scans the memory game's board state onto a 4x4 LED matrix. It takes the game controller's grid rows (A = hidden pattern, B = revealed marks), cursor position and one-hot state flags. It time-multiplexes one row at a time, with blanking between rows, a blinking cursor and a lose-flash. It sits between the game controller and the matrix row/column pins.

## Interface
- SCAN_DIV, 50000: clock cycles per row slot. Must be greater than BLANK.
- BLANK, 16: dead-time cycles at the start of each slot. Must be at least 1.
- BLINK_DIV, 12500000: cycles per half-period of the blink phase.

- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Qi, Qg, Qfo, Qp, Ql  in  1 each  game state flags (initial, generate, findones, play, lose)
- RowA0..RowA3  in  4 each  hidden pattern; bit j of RowAi = cell (row i, column j)
- RowB0..RowB3  in  4 each  revealed marks, same indexing
- CurX  in  2  cursor row index
- CurY  in  2  cursor column (bit) index
- RowSel  out  4  matrix row enables, active-low one-hot; 4'b1111 = all off
- ColOut  out  4  column drive for the selected row, active-high
- FrameTick  out  1  one-cycle pulse at the end of each full 4-row frame

## Operation

**Counters**
- slot_cnt counts 0..SCAN_DIV-1 and wraps to 0.
- On that wrap edge, row_idx advances 0,1,2,3,0.
- blink_cnt counts 0..BLINK_DIV-1. On its wrap edge, blink_on toggles.
- The blink counters run free and are independent of the scan.

**Pattern selection** (evaluated for row r = row_idx; priority top-down)
- Ql=1: all four bits = blink_on.
- Qp=1: RowBr, except when r==CurX, where bit CurY is forced to blink_on.
- Qg=1 or Qfo=1: RowAr (preview).
- Otherwise (Qi, or no flag set): 4'b0000.
- Multiple flags set: the highest-priority flag wins. No error is raised.

**Output registers**
- On the edge ending a cycle with slot_cnt==BLANK-1: RowSel <= ~(1<<row_idx), ColOut <= pattern. This is the only capture point.
- On the edge ending a cycle with slot_cnt==SCAN_DIV-1: RowSel <= 4'b1111, ColOut <= 4'b0000.
- FrameTick is registered: it is 1 for exactly the cycle after the edge where row_idx==3 and slot_cnt==SCAN_DIV-1.
- Inputs may change at any time. Changes to flags, rows or cursor during an active window have no effect until the next capture point (no tearing).

**Reset** (synchronous, Reset sampled high)
- slot_cnt=0, row_idx=0, blink_cnt=0, blink_on=1.
- RowSel=4'b1111, ColOut=4'b0000, FrameTick=0.
- Reset mid-slot aborts the slot immediately: outputs are blank on the next cycle, and scanning restarts at row 0.

## Timing
- Slot layout: slot_cnt 0..BLANK-1 is blank (RowSel=1111, ColOut=0); slot_cnt BLANK..SCAN_DIV-1 drives the captured row.
- Each row is active for SCAN_DIV-BLANK cycles. Frame period is 4*SCAN_DIV cycles.
- After Reset deasserts, the first cycle has slot_cnt=0. RowSel becomes 4'b1110 starting at the BLANK-th cycle after release.
- Input-to-output latency is at most one slot (next capture). The capture itself is one cycle.
- Blink phase is sampled only at capture. The cursor and lose-flash update at slot granularity, not mid-slot.
- Counter widths must hold SCAN_DIV-1 and BLINK_DIV-1. Wrap is by comparison, not by power-of-two overflow.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK=2, BLINK_DIV=20.
- Reset: hold Reset 3 cycles, then release -> RowSel=1111, ColOut=0000 through 2 cycles; RowSel=1110 in cycles 2..7 after release, then 1111 for 2 cycles, then 1101.
- Preview: Qfo=1, RowA0=1010, RowA1=0101, RowA2=1111, RowA3=0001 -> ColOut 1010/0101/1111/0001 in the active windows of rows 0..3; FrameTick high exactly once every 32 cycles.
- Cursor: Qp=1, all RowB=0000, CurX=2, CurY=1 -> row 2 ColOut=0010 when blink_on=1 and 0000 when blink_on=0; rows 0, 1, 3 always 0000. Repeat with RowB2=0010 -> row 2 stays 0010 only while blink_on=1; RowB2=1000 -> shows 1010 or 1000.
- Lose priority: Qp=1 and Ql=1 together -> every row ColOut=1111 in blink_on=1 slots and 0000 otherwise, ignoring RowB and the cursor.
- No tearing: Qp=1, change RowB1 from 0000 to 1100 at slot_cnt=4 of row 1 -> ColOut stays 0000 through row 1's window; 1100 appears in row 1's next-frame window.
- Reset mid-scan: assert Reset at row_idx=2, slot_cnt=5 -> next cycle RowSel=1111, ColOut=0000, FrameTick=0; after release, row 0 is the first row driven.

Source files
------------

// File: rtl/memory_board_scan.sv
// rtl/memory_board_scan.sv - 4x4 LED matrix scanner for the memory game board.
// One row per slot: a blank lead-in, one capture, then the row is held steady.
module memory_board_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK     = 16,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Qi,
    input  logic       Qg,
    input  logic       Qfo,
    input  logic       Qp,
    input  logic       Ql,
    input  logic [3:0] RowA0,
    input  logic [3:0] RowA1,
    input  logic [3:0] RowA2,
    input  logic [3:0] RowA3,
    input  logic [3:0] RowB0,
    input  logic [3:0] RowB1,
    input  logic [3:0] RowB2,
    input  logic [3:0] RowB3,
    input  logic [1:0] CurX,
    input  logic [1:0] CurY,
    output logic [3:0] RowSel,
    output logic [3:0] ColOut,
    output logic       FrameTick
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_CAP   = SW'(BLANK - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] r_slot;
    logic [1:0]    r_row;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [3:0]    r_row_sel;
    logic [3:0]    r_col_out;
    logic          r_frame_tick;

    logic          w_slot_wrap;
    logic          w_slot_cap;
    logic          w_blink_wrap;
    logic          w_cursor_row;
    logic [3:0]    w_row_a;
    logic [3:0]    w_row_b;
    logic [3:0]    w_pattern;

    assign w_slot_wrap  = (r_slot == SLOT_LAST);
    assign w_slot_cap   = (r_slot == SLOT_CAP);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_cursor_row = (r_row == CurX);

    always_comb begin
        w_row_a = RowA0;
        w_row_b = RowB0;
        case (r_row)
            2'd1: begin
                w_row_a = RowA1;
                w_row_b = RowB1;
            end
            2'd2: begin
                w_row_a = RowA2;
                w_row_b = RowB2;
            end
            2'd3: begin
                w_row_a = RowA3;
                w_row_b = RowB3;
            end
            default: begin
                w_row_a = RowA0;
                w_row_b = RowB0;
            end
        endcase
    end

    // Flag priority: lose > play > generate/findones > initial/idle (dark board).
    always_comb begin
        w_pattern = 4'b0000;
        if (Ql) begin
            w_pattern = {4{r_blink_on}};
        end else if (Qp) begin
            w_pattern = w_row_b;
            if (w_cursor_row) begin
                w_pattern[CurY] = r_blink_on;
            end
        end else if (Qg || Qfo) begin
            w_pattern = w_row_a;
        end else if (Qi) begin
            w_pattern = 4'b0000;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_slot <= '0;
            r_row  <= 2'd0;
        end else if (w_slot_wrap) begin
            r_slot <= '0;
            r_row  <= r_row + 2'd1;
        end else begin
            r_slot <= r_slot + SW'(1);
        end
    end

    // Blink phase runs free of the scan so its rate does not depend on SCAN_DIV.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_blink_wrap) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Single capture point per slot: inputs moving mid-window never reach the pins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_row_sel    <= 4'b1111;
            r_col_out    <= 4'b0000;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_slot_wrap && (r_row == 2'd3);
            if (w_slot_cap) begin
                r_row_sel <= ~(4'b0001 << r_row);
                r_col_out <= w_pattern;
            end else if (w_slot_wrap) begin
                r_row_sel <= 4'b1111;
                r_col_out <= 4'b0000;
            end
        end
    end

    assign RowSel    = r_row_sel;
    assign ColOut    = r_col_out;
    assign FrameTick = r_frame_tick;

endmodule

// File: tb/tb_memory_board_scan.sv
// tb/tb_memory_board_scan.sv - testbench for memory_board_scan.
module tb_memory_board_scan;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK     = 2;
    localparam int BLINK_DIV = 20;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Qi, Qg, Qfo, Qp, Ql;
    logic [3:0][3:0]  ra, rb;
    logic [1:0]       CurX, CurY;
    logic [3:0]       RowSel, ColOut;
    logic             FrameTick;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               t = 0;
    logic [3:0]       m_cap = 4'b0000;
    logic [3:0]       s_rowsel, s_col;
    logic             s_ft;
    int               s_t;

    typedef struct packed {
        logic [4:0]  flags;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  cx;
        logic [1:0]  cy;
        logic [15:0] on;
        logic [15:0] off;
    } vec_t;

    vec_t vecs[9];

    memory_board_scan #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Qi       (Qi),
        .Qg       (Qg),
        .Qfo      (Qfo),
        .Qp       (Qp),
        .Ql       (Ql),
        .RowA0    (ra[0]),
        .RowA1    (ra[1]),
        .RowA2    (ra[2]),
        .RowA3    (ra[3]),
        .RowB0    (rb[0]),
        .RowB1    (rb[1]),
        .RowB2    (rb[2]),
        .RowB3    (rb[3]),
        .CurX     (CurX),
        .CurY     (CurY),
        .RowSel   (RowSel),
        .ColOut   (ColOut),
        .FrameTick(FrameTick)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic blink_at(int tt);
        return ((tt / BLINK_DIV) % 2) == 0;
    endfunction

    function automatic logic [3:0] ref_pattern(int r, logic bl);
        logic [3:0] p;
        p = 4'b0000;
        if (Ql) begin
            p = {4{bl}};
        end else if (Qp) begin
            p = rb[r];
            if (r == int'(CurX)) p[CurY] = bl;
        end else if (Qg || Qfo) begin
            p = ra[r];
        end
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0d", name, act, exp, s_t);
        end
    endtask

    task automatic run_cycle();
        int         slot;
        int         row;
        logic [3:0] e_sel;
        @(negedge Clk);
        slot     = t % SCAN_DIV;
        row      = (t / SCAN_DIV) % 4;
        s_rowsel = RowSel;
        s_col    = ColOut;
        s_ft     = FrameTick;
        s_t      = t;
        if (slot < BLANK) begin
            chk("model_rowsel", RowSel, 4'hF);
            chk("model_colout", ColOut, 0);
        end else begin
            e_sel = ~(4'b0001 << row);
            chk("model_rowsel", RowSel, e_sel);
            chk("model_colout", ColOut, m_cap);
        end
        chk("model_frametick", FrameTick, (t > 0 && (t % FRAME) == 0) ? 1 : 0);
        if (slot == BLANK - 1) m_cap = ref_pattern(row, blink_at(t));
        @(posedge Clk);
        #1;
        t = Reset ? 0 : t + 1;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) @(posedge Clk);
        #1;
        Reset = 1'b0;
        t = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        {Qi, Qg, Qfo, Qp, Ql} = v.flags;
        ra   = v.a;
        rb   = v.b;
        CurX = v.cx;
        CurY = v.cy;
    endtask

    function automatic vec_t mk(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] cx, input logic [1:0] cy,
                                input logic [15:0] on, input logic [15:0] off);
        vec_t v;
        v.flags = f; v.a = a; v.b = b; v.cx = cx; v.cy = cy; v.on = on; v.off = off;
        return v;
    endfunction

    initial begin
        logic [3:0] rs_exp[12];
        {Qi, Qg, Qfo, Qp, Ql} = 5'b00000;
        ra = '0; rb = '0; CurX = 2'd0; CurY = 2'd0;

        // flags = {Qi,Qg,Qfo,Qp,Ql}; rows packed {row3,row2,row1,row0}
        vecs[0] = mk(5'b00100, 16'h1F5A, 16'h0000, 2'd0, 2'd0, 16'h1F5A, 16'h1F5A);
        vecs[1] = mk(5'b00010, 16'hFFFF, 16'h0000, 2'd2, 2'd1, 16'h0200, 16'h0000);
        vecs[2] = mk(5'b00010, 16'hFFFF, 16'h0200, 2'd2, 2'd1, 16'h0200, 16'h0000);
        vecs[3] = mk(5'b00010, 16'h0000, 16'h0800, 2'd2, 2'd1, 16'h0A00, 16'h0800);
        vecs[4] = mk(5'b00011, 16'h5555, 16'h1234, 2'd1, 2'd3, 16'hFFFF, 16'h0000);
        vecs[5] = mk(5'b10000, 16'hFFFF, 16'hFFFF, 2'd0, 2'd0, 16'h0000, 16'h0000);
        vecs[6] = mk(5'b11000, 16'h8421, 16'h0000, 2'd3, 2'd3, 16'h8421, 16'h8421);
        vecs[7] = mk(5'b00000, 16'hFFFF, 16'hFFFF, 2'd1, 2'd1, 16'h0000, 16'h0000);
        vecs[8] = mk(5'b00010, 16'h0000, 16'h0F0F, 2'd0, 2'd2, 16'h0F0F, 16'h0F0B);

        rs_exp = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD};
        apply_vec(vecs[0]);
        do_reset(3);
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            chk("reset_seq_rowsel", s_rowsel, rs_exp[i]);
            if (i < 2) chk("reset_colout", s_col, 0);
        end

        for (int vi = 0; vi < 9; vi++) begin
            vec_t v;
            int   ft_cnt;
            v = vecs[vi];
            apply_vec(v);
            do_reset(3);
            ft_cnt = 0;
            for (int c = 0; c < 3 * FRAME; c++) begin
                int slot, row, tcap;
                logic [3:0] e;
                run_cycle();
                if (s_ft) ft_cnt++;
                slot = s_t % SCAN_DIV;
                if (slot >= BLANK) begin
                    row  = (s_t / SCAN_DIV) % 4;
                    tcap = s_t - slot + BLANK - 1;
                    e    = blink_at(tcap) ? v.on[row*4 +: 4] : v.off[row*4 +: 4];
                    chk($sformatf("vec%0d_row%0d", vi, row), s_col, e);
                end
            end
            chk($sformatf("vec%0d_frametick_count", vi), ft_cnt, 2);
        end

        // row 1's window must not tear when its row data changes mid-window
        apply_vec(mk(5'b00010, 16'h0000, 16'h0000, 2'd3, 2'd0, 16'h0, 16'h0));
        do_reset(3);
        while (t < 12) run_cycle();
        rb[1] = 4'b1100;
        while (t < 48) begin
            run_cycle();
            if (s_t >= 10 && s_t <= 15) chk("no_tear", s_col, 0);
            if (s_t >= 42 && s_t <= 47) chk("tear_next_frame", s_col, 4'b1100);
        end

        // reset in the middle of row 2's window
        apply_vec(vecs[4]);
        do_reset(3);
        while (t < 21) run_cycle();
        Reset = 1'b1;
        run_cycle();
        Reset = 1'b0;
        run_cycle();
        chk("midrst_rowsel", s_rowsel, 4'hF);
        chk("midrst_colout", s_col, 0);
        chk("midrst_frametick", s_ft, 0);
        run_cycle();
        run_cycle();
        chk("midrst_first_row0", s_rowsel, 4'hE);

        // randomized inputs and occasional resets against the reference model
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) {Qi, Qg, Qfo, Qp, Ql} = 5'($urandom) & 5'($urandom);
            if ($urandom_range(0, 5) == 0) ra[$urandom_range(0, 3)] = 4'($urandom);
            if ($urandom_range(0, 5) == 0) rb[$urandom_range(0, 3)] = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                CurX = 2'($urandom);
                CurY = 2'($urandom);
            end
            Reset = ($urandom_range(0, 299) == 0);
            run_cycle();
        end
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
